// File: rtl/dram_req_arbiter_pkg.sv
// dram_req_arbiter_pkg: libmemif shared constants, command FSM state type and tag-width helper
package libmemif;
   localparam int DRAM_WBEATS = 2;
   typedef enum logic [1:0] {IDLE, ISSUE, WBEAT1} dram_arb_state_type;
   function automatic int tag_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/dram_req_arbiter_rd_tag_fifo.sv
// dram_rd_tag_fifo: in-order FIFO of requester indices for outstanding reads
//   push/din: enqueue a tag; pop: drop head; head: oldest tag; full/empty: occupancy flags
module dram_rd_tag_fifo import libmemif::*; #(
   parameter int DEPTH = 8,
   parameter int W     = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          do_push, do_pop;
   assign full  = cnt_q == (AW+1)'(DEPTH);
   assign empty = cnt_q == '0;
   assign head  = mem_q[rp_q];
   always_comb begin
      do_push = push && !full;
      do_pop  = pop && !empty;
      wp_d    = do_push ? wp_q + AW'(1) : wp_q;
      rp_d    = do_pop ? rp_q + AW'(1) : rp_q;
      cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
      if (do_push) mem_q[wp_q] <= din;
   end
endmodule

// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: round-robin sharing of the DDR2 user port among NREQ requesters
//   req_*: requester command side (valid/write/addr/wdata in, one-hot ready out)
//   rdata*: read beats steered to the owning requester; err: sticky orphan-beat flag
//   af_*/wb_*/rb_*: MIG address FIFO, write buffer and read buffer
module dram_req_arbiter import libmemif::*; #(
   parameter int NREQ     = 2,
   parameter int ADDRW    = 25,
   parameter int TAGDEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NREQ-1:0]            req_valid,
   input  logic [NREQ-1:0]            req_write,
   input  logic [NREQ-1:0][ADDRW-1:0] req_addr,
   input  logic [NREQ-1:0][255:0]     req_wdata,
   output logic [NREQ-1:0]            req_ready,
   output logic [127:0]               rdata,
   output logic [NREQ-1:0]            rdata_valid,
   output logic                       rdata_last,
   output logic                       err,
   output logic                       af_wren,
   output logic [ADDRW-1:0]           af_addr,
   output logic                       af_read,
   input  logic                       af_full,
   output logic                       wb_wren,
   output logic [127:0]               wb_data,
   input  logic                       wb_full,
   input  logic                       rb_empty,
   input  logic [127:0]               rb_data,
   output logic                       rb_re
);
   localparam int TW = tag_w(NREQ);
   dram_arb_state_type state_q, state_d;
   logic [TW-1:0]    last_q, last_d, win_q, win_d, cand, pick, tag_head;
   logic             wr_q, wr_d, found, go, tag_full, tag_empty, hit;
   logic [127:0]     hi_q, hi_d, wb_data_q, wb_data_d;
   logic             af_wren_q, af_wren_d, af_read_q, af_read_d, wb_wren_q, wb_wren_d;
   logic [ADDRW-1:0] af_addr_q, af_addr_d;
   logic [NREQ-1:0]  ready_q, ready_d;
   logic             rbeat_q, rbeat_d, err_q, err_d;
   assign req_ready = ready_q;
   assign af_wren   = af_wren_q;
   assign af_addr   = af_addr_q;
   assign af_read   = af_read_q;
   assign wb_wren   = wb_wren_q;
   assign wb_data   = wb_data_q;
   assign err       = err_q;
   // Return path: pop whenever data is present, even with no owner, so the read buffer never wedges.
   assign rb_re       = !rb_empty && !rst;
   assign hit         = rb_re && !tag_empty;
   assign rdata       = rb_re ? rb_data : '0;
   assign rdata_valid = hit ? (NREQ'(1) << tag_head) : '0;
   assign rdata_last  = hit && rbeat_q;
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = TW'((int'(last_q) + k) % NREQ);
         if (!found && req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
      // Only the first valid requester is considered; if it is blocked nobody else jumps ahead.
      go        = state_q == IDLE && found && !af_full && (req_write[pick] ? !wb_full : !tag_full);
      state_d   = state_q;
      last_d    = last_q;
      win_d     = win_q;
      wr_d      = wr_q;
      hi_d      = hi_q;
      af_wren_d = 1'b0;
      af_read_d = af_read_q;
      af_addr_d = af_addr_q;
      ready_d   = '0;
      wb_wren_d = 1'b0;
      wb_data_d = wb_data_q;
      rbeat_d   = hit ? !rbeat_q : rbeat_q;
      err_d     = err_q || (rb_re && tag_empty);
      case (state_q)
         IDLE: if (go) begin
            state_d       = ISSUE;
            last_d        = pick;
            win_d         = pick;
            wr_d          = req_write[pick];
            hi_d          = req_wdata[pick][255:128];
            af_wren_d     = 1'b1;
            af_read_d     = !req_write[pick];
            af_addr_d     = req_addr[pick];
            ready_d[pick] = 1'b1;
            wb_wren_d     = req_write[pick];
            wb_data_d     = req_write[pick] ? req_wdata[pick][127:0] : wb_data_q;
         end
         ISSUE: begin
            state_d   = wr_q ? WBEAT1 : IDLE;
            wb_wren_d = wr_q;
            wb_data_d = wr_q ? hi_q : wb_data_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= TW'(NREQ - 1);
         win_q     <= '0;
         wr_q      <= 1'b0;
         hi_q      <= '0;
         af_wren_q <= 1'b0;
         af_read_q <= 1'b0;
         af_addr_q <= '0;
         ready_q   <= '0;
         wb_wren_q <= 1'b0;
         wb_data_q <= '0;
         rbeat_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         win_q     <= win_d;
         wr_q      <= wr_d;
         hi_q      <= hi_d;
         af_wren_q <= af_wren_d;
         af_read_q <= af_read_d;
         af_addr_q <= af_addr_d;
         ready_q   <= ready_d;
         wb_wren_q <= wb_wren_d;
         wb_data_q <= wb_data_d;
         rbeat_q   <= rbeat_d;
         err_q     <= err_d;
      end
   end
   dram_rd_tag_fifo #(.DEPTH(TAGDEPTH), .W(TW)) u_tags (
      .clk   (clk),
      .rst   (rst),
      .push  (state_q == ISSUE && !wr_q),
      .din   (win_q),
      .pop   (hit && rbeat_q),
      .head  (tag_head),
      .full  (tag_full),
      .empty (tag_empty)
   );
endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter: directed and randomized checks of dram_req_arbiter against a transaction-level model
module tb_dram_req_arbiter;
   localparam int NREQ  = 2;
   localparam int ADDRW = 25;
   localparam int TD    = 8;
   logic clk = 1'b0;
   logic rst;
   logic [NREQ-1:0] req_valid, req_write, req_ready, rdata_valid;
   logic [NREQ-1:0][ADDRW-1:0] req_addr;
   logic [NREQ-1:0][255:0] req_wdata;
   logic [127:0] rdata, wb_data, rb_data;
   logic rdata_last, err, af_wren, af_read, af_full, wb_wren, wb_full, rb_empty, rb_re;
   logic [ADDRW-1:0] af_addr;
   int checks = 0, errors = 0;
   int cyc = 0, next_arb = 0, last = NREQ - 1, iss_at = -1, b1_at = -1, iss_w = 0;
   bit iss_wr = 0, beat = 0, m_err = 0, m_read = 0, rnd = 0, drain = 0;
   logic [ADDRW-1:0] iss_a = '0, m_addr = '0;
   logic [255:0] iss_d = '0;
   logic [127:0] m_wdata = '0;
   logic [NREQ-1:0] auto_rd = '0;
   int q[$];
   always #5 clk = ~clk;
   dram_req_arbiter #(.NREQ(NREQ), .ADDRW(ADDRW), .TAGDEPTH(TD)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rdata(rdata), .rdata_valid(rdata_valid),
      .rdata_last(rdata_last), .err(err), .af_wren(af_wren), .af_addr(af_addr), .af_read(af_read),
      .af_full(af_full), .wb_wren(wb_wren), .wb_data(wb_data), .wb_full(wb_full),
      .rb_empty(rb_empty), .rb_data(rb_data), .rb_re(rb_re)
   );
   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask
   task automatic new_req(input int i, input bit wr);
      req_valid[i] = 1'b1;
      req_write[i] = wr;
      req_addr[i]  = ADDRW'($urandom);
      req_wdata[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endtask
   // One clock cycle: predict outputs, compare mid-cycle, advance the model, then drive the next inputs.
   task automatic tick();
      logic [NREQ-1:0] e_rdy, e_rv;
      logic e_af, e_wb, e_re, e_last;
      int drop;
      e_rdy = '0;
      e_af  = 1'b0;
      e_wb  = 1'b0;
      if (cyc == iss_at) begin
         e_af         = 1'b1;
         e_rdy[iss_w] = 1'b1;
         m_read       = !iss_wr;
         m_addr       = iss_a;
         if (iss_wr) begin
            e_wb    = 1'b1;
            m_wdata = iss_d[127:0];
         end
      end
      if (cyc == b1_at) begin
         e_wb    = 1'b1;
         m_wdata = iss_d[255:128];
      end
      e_re   = !rb_empty && !rst;
      e_rv   = (e_re && q.size() > 0) ? NREQ'(1) << q[0] : '0;
      e_last = e_re && q.size() > 0 && beat;
      @(negedge clk);
      if (!rst) begin
         chk("req_ready", req_ready, e_rdy);
         chk("af_wren", af_wren, e_af);
         chk("af_read", af_read, m_read);
         chk("af_addr", af_addr, m_addr);
         chk("wb_wren", wb_wren, e_wb);
         chk("wb_data", wb_data, m_wdata);
         chk("rb_re", rb_re, e_re);
         chk("rdata_valid", rdata_valid, e_rv);
         chk("rdata_last", rdata_last, e_last);
         chk("err", err, m_err);
         if (e_re) chk("rdata", rdata, rb_data);
      end
      drop = (cyc == iss_at) ? iss_w : -1;
      if (rst) begin
         next_arb = cyc + 1;
         last     = NREQ - 1;
         iss_at   = -1;
         b1_at    = -1;
         q.delete();
         beat     = 0;
         m_err    = 0;
         m_read   = 0;
         m_addr   = '0;
         m_wdata  = '0;
      end else begin
         if (cyc >= next_arb)
            for (int k = 1; k <= NREQ; k++) begin
               int i = (last + k) % NREQ;
               if (req_valid[i]) begin
                  if (!af_full && (req_write[i] ? !wb_full : q.size() < TD)) begin
                     iss_at   = cyc + 1;
                     iss_w    = i;
                     iss_wr   = req_write[i];
                     iss_a    = req_addr[i];
                     iss_d    = req_wdata[i];
                     b1_at    = iss_wr ? cyc + 2 : -1;
                     next_arb = cyc + (iss_wr ? 3 : 2);
                     last     = i;
                  end
                  break;
               end
            end
         if (e_re) begin
            if (q.size() > 0) begin
               if (beat) void'(q.pop_front());
               beat = !beat;
            end else m_err = 1;
         end
         if (cyc == iss_at && !iss_wr) q.push_back(iss_w);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (drop >= 0) begin
         req_valid[drop] = 1'b0;
         if (auto_rd[drop]) new_req(drop, 1'b0);
      end
      if (rnd) begin
         af_full = $urandom_range(0, 4) == 0;
         wb_full = $urandom_range(0, 4) == 0;
         for (int i = 0; i < NREQ; i++)
            if (!req_valid[i] && $urandom_range(0, 2) == 0) new_req(i, 1'($urandom_range(0, 1)));
      end
      if (rnd || drain) begin
         rb_empty = !(q.size() > 0 && (drain || $urandom_range(0, 2) == 0));
         rb_data  = {$urandom, $urandom, $urandom, $urandom};
      end
   endtask
   task automatic drain_all();
      int k;
      auto_rd  = '0;
      af_full  = 1'b0;
      wb_full  = 1'b0;
      drain    = 1;
      rb_empty = !(q.size() > 0);
      for (k = 0; k < 300 && (q.size() > 0 || req_valid != '0 || cyc < next_arb); k++) tick();
      drain    = 0;
      rb_empty = 1'b1;
      checks++;
      assert (k < 300) else begin
         errors++;
         $error("FAIL drain_timeout pending=%0d required=0", q.size());
      end
   endtask
   initial begin
      rst = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      af_full = 1'b0; wb_full = 1'b0; rb_empty = 1'b1; rb_data = '0;
      @(posedge clk);
      #1;
      repeat (2) tick();
      rst = 1'b0;
      repeat (2) tick();
      // single write from requester 0
      req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 25'h123;
      req_wdata[0] = {128'hB1B1_B1B1_0000_1111_2222_3333_4444_5555, 128'hB0B0_B0B0_6666_7777_8888_9999_AAAA_CCCC};
      repeat (5) tick();
      // continuous reads from both requesters, then the lines come back
      auto_rd = '1; new_req(0, 1'b0); new_req(1, 1'b0);
      repeat (10) tick();
      auto_rd = '0;
      rb_empty = 1'b0;
      repeat (8) begin
         rb_data = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      rb_empty = 1'b1;
      drain_all();
      // address FIFO almost-full holds off a write
      af_full = 1'b1; new_req(1, 1'b1);
      repeat (5) tick();
      af_full = 1'b0;
      repeat (5) tick();
      // fill the tag FIFO, block the ninth read, release one line
      auto_rd = '1; new_req(0, 1'b0); new_req(1, 1'b0);
      for (int k = 0; k < 60 && q.size() < TD; k++) tick();
      repeat (6) tick();
      rb_empty = 1'b0;
      repeat (2) begin
         rb_data = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end
      rb_empty = 1'b1;
      auto_rd = '0;
      repeat (4) tick();
      drain_all();
      // randomized traffic
      rnd = 1;
      repeat (2500) tick();
      rnd = 0;
      drain_all();
      // orphan read beat sets a sticky error
      rb_empty = 1'b0; rb_data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      rb_empty = 1'b1;
      repeat (3) tick();
      chk("err_sticky", err, 1'b1);
      // reset while the second write beat is on the bus
      new_req(0, 1'b1);
      for (int k = 0; k < 20 && cyc != b1_at; k++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      new_req(0, 1'b0); new_req(1, 1'b0);
      tick();
      chk("post_rst_grant", req_ready, NREQ'(1));
      drain_all();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
